xoodoo_rdi_prng: RTL



---
 rtl/xoodoo_rdi_pkg.sv | 17 +
 rtl/xorshift32_step.sv | 17 +
 rtl/xoodoo_rdi_prng.sv | 136 +++++++++++++
 3 files changed

// File: rtl/xoodoo_rdi_pkg.sv
// Shared types and constants for the Xoodoo fresh-randomness source.
// Holds the FSM encoding, the xorshift shift amounts and the zero-seed fix.
package xoodoo_rdi_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;

  localparam logic [31:0] ZERO_FIX_DEF = 32'h9E3779B9;

endpackage

// File: rtl/xorshift32_step.sv
// One combinational xorshift32 step.
// x ^= x<<13; x ^= x>>17; x ^= x<<5
module xorshift32_step
  import xoodoo_rdi_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [31:0] a;
  logic [31:0] b;

  assign a = x ^ (x << XS_A);
  assign b = a ^ (a >> XS_B);
  assign y = b ^ (b << XS_C);

endmodule

// File: rtl/xoodoo_rdi_prng.sv
// Parallel xorshift32 random source feeding the Xoodoo core's rdi port.
// Seeded one lane per handshake, warmed up, then stepped per consumed word.
module xoodoo_rdi_prng
  import xoodoo_rdi_pkg::*;
#(
  parameter int          LANES         = 12,
  parameter int          WARMUP_CYCLES = 16,
  parameter logic [31:0] ZERO_FIX      = ZERO_FIX_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           seed_i,
  input  logic                  seed_valid_i,
  output logic                  seed_ready_o,
  input  logic                  reseed_i,
  output logic [32*LANES-1:0]   rdi_o,
  output logic                  rdi_valid_o,
  input  logic                  rdi_ready_i,
  output logic                  seeded_o
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW = (WARMUP_CYCLES > 0) ?
                      $clog2(WARMUP_CYCLES + 1) : 1;

  localparam logic [CW-1:0] LAST  = CW'(LANES - 1);
  localparam logic [WW-1:0] WLOAD =
    WW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [WW-1:0] wcnt_q;
  logic [WW-1:0] wcnt_d;

  logic [31:0] lane_q [LANES];
  logic [31:0] lane_s [LANES];
  logic [31:0] seed_fix;

  logic seed_hs;
  logic rdi_hs;
  logic step_en;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    xorshift32_step u_step (
      .x (lane_q[g]),
      .y (lane_s[g])
    );
    assign rdi_o[32*g +: 32] = lane_q[g];
  end

  // A reseed request overrides any seed word offered in the same cycle
  assign seed_hs = (state_q == LOAD) & seed_valid_i & ~reseed_i;
  assign rdi_hs  = (state_q == RUN) & rdi_ready_i;
  assign step_en = rdi_hs | ((state_q == WARMUP) & ~reseed_i);

  assign seed_fix = (seed_i == 32'd0) ?
                    (ZERO_FIX ^ 32'(cnt_q)) : seed_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (step_en) begin
          lane_q[i] <= lane_s[i];
        end else if (seed_hs && cnt_q == CW'(i)) begin
          lane_q[i] <= seed_fix;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      LOAD: begin
        if (reseed_i) begin
          cnt_d = '0;
        end else if (seed_hs) begin
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            wcnt_d = WLOAD;
            state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WARMUP: begin
        if (reseed_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (wcnt_q == '0) begin
          state_d = RUN;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      RUN: begin
        if (reseed_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    seed_ready_o = (state_q == LOAD);
    rdi_valid_o  = (state_q == RUN);
    seeded_o     = (state_q == RUN);
  end

endmodule
